instr_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_opcode_decode.sv | 47 ++++
 rtl/instr_sequencer.sv | 95 +++++++++
 tb/tb_instr_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: state codes, opcodes, ALU encodings and
// instruction field positions used by the sequencer and the output-signal decoder.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,
    S_LOAD     = 5'd1,
    S_MOV      = 5'd2,
    S_ARITH_A  = 5'd3,
    S_ARITH_G  = 5'd4,
    S_ARITH_WB = 5'd5,
    S_BRANCH   = 5'd6,
    S_DONE     = 5'd7
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD   = 3'b000,
    OP_MOV    = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_BRANCH = 3'b110,
    OP_NOP    = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int unsigned OPC_MSB = 22;
  localparam int unsigned OPC_LSB = 20;
  localparam int unsigned RX_MSB  = 19;
  localparam int unsigned RX_LSB  = 16;
  localparam int unsigned RY_MSB  = 15;
  localparam int unsigned RY_LSB  = 12;
  localparam int unsigned TGT_MSB = 15;
  localparam int unsigned TGT_LSB = 0;

  function automatic opcode_e get_opcode(input logic [22:0] word);
    return opcode_e'(word[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction handshake and control-output bundle between the sequencer
// (slave) and whoever feeds instructions and consumes the control strobes (master).
interface instr_sequencer_if #(
  parameter int unsigned INSTR_W = 23,
  parameter int unsigned STATE_W = 5
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_in;
  logic               instr_ready;
  logic               hold;
  logic [STATE_W-1:0] state;
  logic [INSTR_W-1:0] instr;
  logic [1:0]         alu_op;
  logic               pc_step;
  logic               branch;
  logic [15:0]        pc_target;
  logic               retire;
  logic               busy;

  modport master (
    output instr_valid, instr_in, hold,
    input  instr_ready, state, instr, alu_op, pc_step, branch, pc_target, retire, busy
  );

  modport slave (
    input  instr_valid, instr_in, hold,
    output instr_ready, state, instr, alu_op, pc_step, branch, pc_target, retire, busy
  );
endinterface

// File: rtl/instr_opcode_decode.sv
// Combinational opcode-to-dispatch mapping. INSTR_SEQ_BRANCH_EN routes opcode 110
// through BRANCH; without it opcode 110 behaves as a NOP.
module instr_opcode_decode
  import cpu_pkg::*;
(
  input  opcode_e i_opcode,
  output state_e  o_next_state,
  output alu_op_e o_alu_op,
  output logic    o_is_branch
);

  always_comb begin
    o_next_state = S_DONE;
    o_alu_op     = ALU_ADD;
    o_is_branch  = 1'b0;
    unique case (i_opcode)
      OP_LOAD: o_next_state = S_LOAD;
      OP_MOV:  o_next_state = S_MOV;
      OP_ADD: begin
        o_next_state = S_ARITH_A;
        o_alu_op     = ALU_ADD;
      end
      OP_SUB: begin
        o_next_state = S_ARITH_A;
        o_alu_op     = ALU_SUB;
      end
      OP_AND: begin
        o_next_state = S_ARITH_A;
        o_alu_op     = ALU_AND;
      end
      OP_OR: begin
        o_next_state = S_ARITH_A;
        o_alu_op     = ALU_OR;
      end
`ifdef INSTR_SEQ_BRANCH_EN
      OP_BRANCH: begin
        o_next_state = S_BRANCH;
        o_is_branch  = 1'b1;
      end
`else
      OP_BRANCH: o_next_state = S_DONE;
`endif
      OP_NOP:  o_next_state = S_DONE;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: accepts one instruction, walks its state
// codes and emits retire/pc strobes. Optional branch support: INSTR_SEQ_BRANCH_EN.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_W    = 23,
  parameter int unsigned STATE_W    = 5,
  parameter int unsigned ALU_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  instr_sequencer_if.slave bus
);

  localparam logic [3:0] CntInit = 4'(ALU_CYCLES - 1);

  state_e             r_state;
  logic [INSTR_W-1:0] r_instr;
  alu_op_e            r_alu_sel;
  alu_op_e            r_alu_op;
  logic [3:0]         r_cnt;
  logic               r_taken;

  opcode_e w_opcode;
  state_e  w_next_state;
  alu_op_e w_alu_op;
  logic    w_is_branch;
  logic    w_fire;

  assign w_opcode = get_opcode(bus.instr_in);

  instr_opcode_decode u_decode (
    .i_opcode    (w_opcode),
    .o_next_state(w_next_state),
    .o_alu_op    (w_alu_op),
    .o_is_branch (w_is_branch)
  );

  // hold freezes every register; reset still wins over it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_alu_sel <= ALU_ADD;
      r_alu_op  <= ALU_ADD;
      r_cnt     <= '0;
      r_taken   <= 1'b0;
    end else if (!bus.hold) begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            r_instr   <= bus.instr_in;
            r_state   <= w_next_state;
            r_alu_sel <= w_alu_op;
            r_taken   <= w_is_branch;
          end
        end
        S_LOAD, S_MOV, S_ARITH_WB, S_BRANCH: r_state <= S_DONE;
        S_ARITH_A: begin
          r_state  <= S_ARITH_G;
          r_cnt    <= CntInit;
          r_alu_op <= r_alu_sel;
        end
        S_ARITH_G: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_ARITH_WB;
            r_alu_op <= ALU_ADD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are suppressed while held so DONE fires exactly once on release.
  assign w_fire = (r_state == S_DONE) && !bus.hold;

  assign bus.instr_ready = (r_state == S_IDLE) && !bus.hold;
  assign bus.state       = STATE_W'(r_state);
  assign bus.instr       = r_instr;
  assign bus.alu_op      = r_alu_op;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.retire      = w_fire;
  assign bus.pc_step     = w_fire && !r_taken;
  assign bus.branch      = w_fire && r_taken;
`ifdef INSTR_SEQ_BRANCH_EN
  assign bus.pc_target   = r_instr[TGT_MSB:TGT_LSB];
`else
  assign bus.pc_target   = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer (ALU_CYCLES=3) with a retire scoreboard;
// branch expectations follow INSTR_SEQ_BRANCH_EN.
module tb_instr_sequencer;

  localparam int unsigned AluCycles = 3;

  typedef struct {
    int          acc;
    int          lat;
    logic        pc_step;
    logic        branch;
    logic [15:0] tgt;
  } exp_t;

  typedef logic [4:0] seq_t [8];

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   held = 0;
  exp_t sb[$];
  exp_t mon_e;
  seq_t tr;

  instr_sequencer_if #(.INSTR_W(23), .STATE_W(5)) bus ();

  instr_sequencer #(
    .INSTR_W   (23),
    .STATE_W   (5),
    .ALU_CYCLES(AluCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [22:0] w);
    exp_t e;
    e.acc     = 0;
    e.lat     = 1;
    e.pc_step = 1'b1;
    e.branch  = 1'b0;
    e.tgt     = 16'h0000;
    case (w[22:20])
      3'b000, 3'b001: e.lat = 2;
      3'b010, 3'b011, 3'b100, 3'b101: e.lat = 3 + AluCycles;
`ifdef INSTR_SEQ_BRANCH_EN
      3'b110: begin
        e.lat     = 2;
        e.pc_step = 1'b0;
        e.branch  = 1'b1;
        e.tgt     = w[15:0];
      end
`endif
      default: e.lat = 1;
    endcase
    return e;
  endfunction

  // Monitor: pop on retire, push on accept; held cycles stretch the latency.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.busy && bus.hold) held++;
      if (bus.retire) begin
        chk("sb_nonempty_at_retire", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("sb_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat + held));
          chk("sb_pc_step", 32'(bus.pc_step), 32'(mon_e.pc_step));
          chk("sb_branch", 32'(bus.branch), 32'(mon_e.branch));
          chk("sb_pc_target", 32'(bus.pc_target), 32'(mon_e.tgt));
        end
      end
      if (bus.instr_valid && bus.instr_ready) begin
        mon_e     = model(bus.instr_in);
        mon_e.acc = cyc;
        held      = 0;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [22:0] w, input int n, input seq_t seq,
                        input logic [1:0] op);
    bus.instr_valid = 1'b1;
    bus.instr_in    = w;
    step();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_state_%0d", name, i), 32'(bus.state), 32'(seq[i]));
      chk($sformatf("%s_alu_%0d", name, i), 32'(bus.alu_op), (seq[i] == 5'd4) ? 32'(op) : 32'd0);
      step();
    end
    chk($sformatf("%s_back_idle", name), 32'(bus.state), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
    bus.hold        = 1'b0;
    step();
    step();
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_retire", 32'(bus.retire), 32'd0);
    chk("rst_pc_step", 32'(bus.pc_step), 32'd0);
    chk("rst_branch", 32'(bus.branch), 32'd0);
    reset = 1'b0;
    step();

    // MOV: 2, 7, 0
    bus.instr_valid = 1'b1;
    bus.instr_in    = 23'h112000;
    #1 chk("mov_ready", 32'(bus.instr_ready), 32'd1);
    step();
    bus.instr_valid = 1'b0;
    bus.instr_in    = 23'h7FFFFF;
    chk("mov_state", 32'(bus.state), 32'd2);
    chk("mov_instr", 32'(bus.instr), 32'h112000);
    chk("mov_ready_low", 32'(bus.instr_ready), 32'd0);
    chk("mov_busy", 32'(bus.busy), 32'd1);
    step();
    chk("mov_done", 32'(bus.state), 32'd7);
    chk("mov_retire", 32'(bus.retire), 32'd1);
    chk("mov_pc_step", 32'(bus.pc_step), 32'd1);
    chk("mov_instr_stable", 32'(bus.instr), 32'h112000);
    step();
    chk("mov_idle", 32'(bus.state), 32'd0);
    chk("mov_ready_again", 32'(bus.instr_ready), 32'd1);

    tr = '{5'd3, 5'd4, 5'd4, 5'd4, 5'd5, 5'd7, 5'd0, 5'd0};
    run_op("sub", 23'h330000, 6, tr, 2'b01);
    run_op("add", 23'h200000, 6, tr, 2'b00);
    run_op("and", 23'h400000, 6, tr, 2'b10);
    run_op("or", 23'h500000, 6, tr, 2'b11);
    tr = '{5'd1, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    run_op("load", 23'h000000, 2, tr, 2'b00);

    // hold in IDLE blocks accept
    bus.hold        = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_in    = 23'h112000;
    #1 chk("hold_idle_ready", 32'(bus.instr_ready), 32'd0);
    step();
    chk("hold_idle_state", 32'(bus.state), 32'd0);
    bus.instr_valid = 1'b0;
    bus.hold        = 1'b0;
    step();

    // hold in DONE for 4 cycles
    bus.instr_valid = 1'b1;
    bus.instr_in    = 23'h700000;
    step();
    bus.instr_valid = 1'b0;
    bus.hold        = 1'b1;
    #1 chk("hold_done_retire0", 32'(bus.retire), 32'd0);
    chk("hold_done_pc0", 32'(bus.pc_step), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold_done_state_%0d", i), 32'(bus.state), 32'd7);
      chk($sformatf("hold_done_retire_%0d", i), 32'(bus.retire), 32'd0);
    end
    step();
    bus.hold = 1'b0;
    #1 chk("hold_rel_state", 32'(bus.state), 32'd7);
    chk("hold_rel_retire", 32'(bus.retire), 32'd1);
    chk("hold_rel_pc_step", 32'(bus.pc_step), 32'd1);
    step();
    chk("hold_rel_idle", 32'(bus.state), 32'd0);
    chk("hold_rel_single", 32'(bus.retire), 32'd0);

    // branch
    bus.instr_valid = 1'b1;
    bus.instr_in    = 23'h60ABCD;
    step();
    bus.instr_valid = 1'b0;
`ifdef INSTR_SEQ_BRANCH_EN
    chk("br_state", 32'(bus.state), 32'd6);
    step();
    chk("br_done", 32'(bus.state), 32'd7);
    chk("br_branch", 32'(bus.branch), 32'd1);
    chk("br_target", 32'(bus.pc_target), 32'hABCD);
    chk("br_pc_step", 32'(bus.pc_step), 32'd0);
`else
    chk("br_done", 32'(bus.state), 32'd7);
    chk("br_branch", 32'(bus.branch), 32'd0);
    chk("br_target", 32'(bus.pc_target), 32'd0);
    chk("br_pc_step", 32'(bus.pc_step), 32'd1);
`endif
    step();

    // reset mid-arith
    bus.instr_valid = 1'b1;
    bus.instr_in    = 23'h200000;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("rmid_in_g", 32'(bus.state), 32'd4);
    reset = 1'b1;
    step();
    chk("rmid_state", 32'(bus.state), 32'd0);
    chk("rmid_instr", 32'(bus.instr), 32'd0);
    chk("rmid_retire", 32'(bus.retire), 32'd0);
    chk("rmid_alu_op", 32'(bus.alu_op), 32'd0);
    reset = 1'b0;
    #1 chk("rmid_ready", 32'(bus.instr_ready), 32'd1);
    step();

    // NOP stream with instr_valid held high
    bus.instr_valid = 1'b1;
    bus.instr_in    = 23'h700000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("nop_ready_%0d", i), 32'(bus.instr_ready), 32'd1);
      step();
      chk($sformatf("nop_done_%0d", i), 32'(bus.state), 32'd7);
      chk($sformatf("nop_retire_%0d", i), 32'(bus.retire), 32'd1);
      chk($sformatf("nop_busy_ready_%0d", i), 32'(bus.instr_ready), 32'd0);
      if (i == 2) bus.instr_valid = 1'b0;
      step();
    end
    chk("nop_idle", 32'(bus.state), 32'd0);
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
